edge_event_arbiter: RTL and testbench
=====================================

// Module: edge_event_arbiter
// PURPOSE
//  Collects one-cycle rising-edge pulses from the edge_detector bank (N_CH debounced buttons/switches).
//  Holds each pulse as a sticky pending flag and arbitrates between channels round-robin.
//  Delivers one event ID at a time to a single consumer (FSM/counter logic) over a valid/ready handshake.
//  Sits between edge_detector outputs and the lab's top-level control FSM.
// PARAMETERS
//  N_CH    4   number of edge-pulse channels (>=1)
//  IDX_W   $clog2(N_CH) (min 1)   width of event ID; derived, not overridden
//  DROP_W  8   width of dropped-event counter (only with EDGE_ARB_DROP_CNT_EN)
// PORTS
//  clk         in   1        system clock (125 MHz)
//  rst_n       in   1        async active-low reset
//  edge_pulse  in   N_CH     one-cycle pulses from edge_detector.edge_detect_pulse
//  evt_valid   out  1        event offered to consumer
//  evt_id      out  IDX_W    channel index of offered event; stable while evt_valid
//  evt_ready   in   1        consumer accepts; handshake = evt_valid & evt_ready at posedge clk
//  pending     out  N_CH     sticky per-channel flags not yet loaded into output slot
//  drop_cnt    out  DROP_W   saturating count of merged pulses (macro only)
// BEHAVIOUR
//  Reset (rst_n=0, async; deassertion sampled on clk):
//   - evt_valid=0, evt_id=0, pending=0, rr_ptr=0, drop_cnt=0; outputs return to these at once even mid-offer.
//  Capture: at posedge, pending[i] <= 1 when edge_pulse[i]=1; cleared only when channel i is loaded into the slot.
//  FSM states:
//   - EMPTY (evt_valid=0): if pending!=0, pick k = first set bit at or after rr_ptr (wrap N_CH-1 -> 0);
//     load slot (evt_id=k, evt_valid=1), clear pending[k], go FULL.
//   - FULL (evt_valid=1): evt_id held stable while !evt_ready.
//     - On handshake: rr_ptr <= (k+1) mod N_CH.
//     - Same edge: if other pending bits set, load next winner using the updated pointer and stay FULL (1 event/clk).
//     - Otherwise go EMPTY.
//  Latency: pulse sampled at edge E0 -> pending after E0 -> evt_valid/evt_id after E1 if slot free; 2 clk minimum.
//  Simultaneous events:
//   - edge_pulse[k] on the same edge pending[k] is loaded into the slot -> pending[k] stays 1 (new event, not a drop).
//   - edge_pulse[i] while pending[i]=1 -> merged into the one flag; counted as a drop.
//   - Pulse on the channel currently in the slot with pending clear -> sets pending; not a drop.
//  Fairness: every pending channel is granted within N_CH handshakes.
//  evt_ready while evt_valid=0 is ignored. N_CH=1: rr_ptr constant 0, evt_id always 0.
// CONFIGURATION
//  Macro EDGE_ARB_DROP_CNT_EN.
//  Defined:
//   - drop_cnt port exists; +1 per channel per merged pulse (sum when several merge in one cycle).
//   - Saturates at 2^DROP_W-1; cleared only by reset.
//  Undefined: port and counter absent; merged pulses silently lost; all other behaviour identical.
// STRUCTURE
//  Shared header edge_evt_defs.vh:
//   - FSM state encodings EVT_EMPTY=1'b0, EVT_FULL=1'b1.
//   - Default N_CH and DROP_W constants.
//  Sub-module rr_pick (combinational).
//   - Inputs: req[N_CH], ptr[IDX_W]. Outputs: gnt_valid, gnt_idx[IDX_W].
//   - Rotate, priority-encode, un-rotate.
//  Top module holds pending regs, slot regs, rr_ptr, FSM and optional counter.
// TESTING (N_CH=4, DROP_W=8, evt_ready=1 unless stated)
//  1. Hold rst_n=0 with random edge_pulse -> evt_valid=0, pending=4'b0000, drop_cnt=0 throughout.
//  2. edge_pulse=4'b0100 for 1 clk at E0 -> evt_valid=1, evt_id=2 after E1, low after E2; pending=0.
//  3. edge_pulse=4'b1011 at E0, rr_ptr=0 -> evt_id sequence 0,1,3 on three consecutive cycles, then evt_valid=0.
//  4. evt_ready=0; pulse ch1 at E0, again at E3 and E5 ->
//     - evt_valid=1, evt_id=1 held stable; pending=4'b0010; drop_cnt=1 (macro on).
//     - Raise evt_ready -> second id=1 event follows next cycle.
//  5. ch0 pulsed every cycle, ch3 pulsed once -> ch3 granted within 2 handshakes of its pulse; no starvation over 100 clk.
//  6. Pull rst_n=0 mid-offer (evt_valid=1, pending=4'b1100) ->
//     - evt_valid=0 and pending=0 before next clk edge.
//     - After release, first grant starts at rr_ptr=0.

Source files
------------

// File: rtl/edge_event_arbiter_pkg.sv
// Shared types and defaults for the edge event arbiter.
// FSM encodings, default sizes and the event-ID width helper.
package edge_event_arbiter_pkg;

    localparam int N_CH_DEF   = 4;
    localparam int DROP_W_DEF = 8;

    typedef enum logic {
        EVT_EMPTY = 1'b0,
        EVT_FULL  = 1'b1
    } evt_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Event handshake bundle between arbiter and consumer.
// master = arbiter (offers events), slave = consumer.
interface edge_event_arbiter_if
    import edge_event_arbiter_pkg::*;
#(
    parameter int N_CH = N_CH_DEF
);
    localparam int IDX_W = idx_width(N_CH);

    logic             evt_valid;
    logic [IDX_W-1:0] evt_id;
    logic             evt_ready;

    modport master (
        output evt_valid,
        output evt_id,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_id,
        output evt_ready
    );

endinterface

// File: rtl/edge_event_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr.
// Rotate, priority-encode, un-rotate folded into one modular scan.
module rr_pick
    import edge_event_arbiter_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int IDX_W = idx_width(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
);

    int c;

    // Scan offsets high to low so the smallest offset wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        c         = 0;
        for (int j = N_CH - 1; j >= 0; j--) begin
            c = (int'(ptr) + j) % N_CH;
            if (req[c]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Sticky edge-pulse collector with round-robin single-slot event output.
// Define EDGE_ARB_DROP_CNT_EN to add the saturating drop_cnt port.
module edge_event_arbiter
    import edge_event_arbiter_pkg::*;
#(
    parameter int N_CH   = N_CH_DEF
`ifdef EDGE_ARB_DROP_CNT_EN
    ,
    parameter int DROP_W = DROP_W_DEF
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_CH-1:0]     edge_pulse,
    output logic [N_CH-1:0]     pending,
`ifdef EDGE_ARB_DROP_CNT_EN
    output logic [DROP_W-1:0]   drop_cnt,
`endif
    edge_event_arbiter_if.master evt
);

    localparam int IDX_W = idx_width(N_CH);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CH - 1);

    evt_state_e       state_q, state_d;
    logic [IDX_W-1:0] slot_q, slot_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N_CH-1:0]  pend_q, pend_d;
    logic [N_CH-1:0]  load_mask;
    logic [IDX_W-1:0] ptr_after;
    logic [IDX_W-1:0] pick_ptr;
    logic             hs;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;

    assign hs        = (state_q == EVT_FULL) && evt.evt_ready;
    assign ptr_after = (slot_q == LAST) ? '0 : slot_q + 1'b1;
    // A same-edge reload must already see the advanced pointer.
    assign pick_ptr  = hs ? ptr_after : ptr_q;

    rr_pick #(
        .N_CH (N_CH),
        .IDX_W(IDX_W)
    ) u_pick (
        .req      (pend_q),
        .ptr      (pick_ptr),
        .gnt_valid(gnt_valid),
        .gnt_idx  (gnt_idx)
    );

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        ptr_d     = ptr_q;
        load_mask = '0;
        if (hs) begin
            ptr_d = ptr_after;
        end
        case (state_q)
            EVT_EMPTY: begin
                if (gnt_valid) begin
                    state_d            = EVT_FULL;
                    slot_d             = gnt_idx;
                    load_mask[gnt_idx] = 1'b1;
                end
            end
            EVT_FULL: begin
                if (hs) begin
                    if (gnt_valid) begin
                        slot_d             = gnt_idx;
                        load_mask[gnt_idx] = 1'b1;
                    end else begin
                        state_d = EVT_EMPTY;
                    end
                end
            end
            default: state_d = EVT_EMPTY;
        endcase
        pend_d = (pend_q & ~load_mask) | edge_pulse;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EVT_EMPTY;
            slot_q  <= '0;
            ptr_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            ptr_q   <= ptr_d;
            pend_q  <= pend_d;
        end
    end

    assign evt.evt_valid = (state_q == EVT_FULL);
    assign evt.evt_id    = slot_q;
    assign pending       = pend_q;

`ifdef EDGE_ARB_DROP_CNT_EN
    localparam logic [DROP_W:0] DROP_MAX = {1'b0, {DROP_W{1'b1}}};

    logic [N_CH-1:0] drop_vec;
    logic [DROP_W:0] drop_sum;

    // A pulse into a flag being loaded this edge is a fresh event.
    assign drop_vec = edge_pulse & pend_q & ~load_mask;

    always_comb begin
        drop_sum = {1'b0, drop_cnt};
        for (int i = 0; i < N_CH; i++) begin
            drop_sum = drop_sum + {{DROP_W{1'b0}}, drop_vec[i]};
        end
        if (drop_sum > DROP_MAX) begin
            drop_sum = DROP_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else begin
            drop_cnt <= drop_sum[DROP_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed scenarios plus random run
// against a rule-level reference model.
module tb_edge_event_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] edge_pulse = '0;
    logic [N-1:0] pending;
`ifdef EDGE_ARB_DROP_CNT_EN
    logic [DW-1:0] drop_cnt;
`endif

    int errors = 0;
    int checks = 0;

    edge_event_arbiter_if #(.N_CH(N)) evt_if ();

    edge_event_arbiter #(
        .N_CH  (N)
`ifdef EDGE_ARB_DROP_CNT_EN
        ,
        .DROP_W(DW)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .edge_pulse(edge_pulse),
        .pending   (pending),
`ifdef EDGE_ARB_DROP_CNT_EN
        .drop_cnt  (drop_cnt),
`endif
        .evt       (evt_if)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic         m_valid;
    int           m_id;
    int           m_ptr;
    logic [N-1:0] m_pend;
    int           m_drop;

    function automatic int first_at_or_after(input logic [N-1:0] req,
                                             input int ptr);
        for (int off = 0; off < N; off++) begin
            if (req[(ptr + off) % N]) return (ptr + off) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_id    = 0;
        m_ptr   = 0;
        m_pend  = '0;
        m_drop  = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] p, input logic rdy);
        logic [N-1:0] old_pend;
        int           won;
        old_pend = m_pend;
        won      = -1;
        if (m_valid && rdy) begin
            m_ptr   = (m_id + 1) % N;
            m_valid = 1'b0;
        end
        if (!m_valid) begin
            won = first_at_or_after(old_pend, m_ptr);
            if (won >= 0) begin
                m_valid     = 1'b1;
                m_id        = won;
                m_pend[won] = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (p[i] && old_pend[i] && i != won) m_drop++;
        end
        if (m_drop > (1 << DW) - 1) m_drop = (1 << DW) - 1;
        m_pend = m_pend | p;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        edge_pulse       = '0;
        evt_if.evt_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        evt_if.evt_ready = 1'b1;
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            edge_pulse = N'($urandom);
            step();
            checks++;
            if (evt_if.evt_valid !== 1'b0 || pending !== 4'b0000
                || evt_if.evt_id !== 2'd0) begin
                errors++;
                $display("FAIL reset_hold: valid=%b pending=%b id=%0d want 0/0000/0",
                         evt_if.evt_valid, pending, evt_if.evt_id);
            end
`ifdef EDGE_ARB_DROP_CNT_EN
            checks++;
            if (drop_cnt !== 8'd0) begin
                errors++;
                $display("FAIL reset_drop: got %0d want 0", drop_cnt);
            end
`endif
        end
        edge_pulse = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        do_reset();
        edge_pulse = 4'b0100;
        step();
        edge_pulse = '0;
        checks++;
        if (evt_if.evt_valid !== 1'b0 || pending !== 4'b0100) begin
            errors++;
            $display("FAIL single_e0: valid=%b pending=%b want 0/0100",
                     evt_if.evt_valid, pending);
        end
        step();
        checks++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 2'd2
            || pending !== 4'b0000) begin
            errors++;
            $display("FAIL single_e1: valid=%b id=%0d pending=%b want 1/2/0000",
                     evt_if.evt_valid, evt_if.evt_id, pending);
        end
        step();
        checks++;
        if (evt_if.evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_e2: valid=%b want 0", evt_if.evt_valid);
        end
    endtask

    task automatic test_burst();
        logic [1:0]   exp_id[3];
        logic [N-1:0] exp_pend[3];
        exp_id   = '{2'd0, 2'd1, 2'd3};
        exp_pend = '{4'b1010, 4'b1000, 4'b0000};
        do_reset();
        edge_pulse = 4'b1011;
        step();
        edge_pulse = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== exp_id[i]
                || pending !== exp_pend[i]) begin
                errors++;
                $display("FAIL burst_%0d: valid=%b id=%0d pending=%b want 1/%0d/%b",
                         i, evt_if.evt_valid, evt_if.evt_id, pending,
                         exp_id[i], exp_pend[i]);
            end
        end
        step();
        checks++;
        if (evt_if.evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL burst_end: valid=%b want 0", evt_if.evt_valid);
        end
    endtask

    task automatic test_stall();
        do_reset();
        evt_if.evt_ready = 1'b0;
        edge_pulse = 4'b0010;
        step();
        edge_pulse = '0;
        step();
        step();
        edge_pulse = 4'b0010;
        step();
        edge_pulse = '0;
        checks++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 2'd1
            || pending !== 4'b0010) begin
            errors++;
            $display("FAIL stall_e3: valid=%b id=%0d pending=%b want 1/1/0010",
                     evt_if.evt_valid, evt_if.evt_id, pending);
        end
`ifdef EDGE_ARB_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL stall_nodrop: got %0d want 0", drop_cnt);
        end
`endif
        step();
        edge_pulse = 4'b0010;
        step();
        edge_pulse = '0;
        checks++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 2'd1
            || pending !== 4'b0010) begin
            errors++;
            $display("FAIL stall_e5: valid=%b id=%0d pending=%b want 1/1/0010",
                     evt_if.evt_valid, evt_if.evt_id, pending);
        end
`ifdef EDGE_ARB_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 8'd1) begin
            errors++;
            $display("FAIL stall_drop: got %0d want 1", drop_cnt);
        end
`endif
        evt_if.evt_ready = 1'b1;
        step();
        checks++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 2'd1
            || pending !== 4'b0000) begin
            errors++;
            $display("FAIL stall_second: valid=%b id=%0d pending=%b want 1/1/0000",
                     evt_if.evt_valid, evt_if.evt_id, pending);
        end
        step();
        checks++;
        if (evt_if.evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_end: valid=%b want 0", evt_if.evt_valid);
        end
    endtask

    task automatic test_fairness();
        int waiting;
        int offers;
        int ch0_grants;
        int ch3_grants;
        do_reset();
        waiting    = 0;
        offers     = 0;
        ch0_grants = 0;
        ch3_grants = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            edge_pulse = (cyc == 10 || cyc == 60) ? 4'b1001 : 4'b0001;
            step();
            if (edge_pulse[3]) begin
                waiting = 1;
                offers  = 0;
                continue;
            end
            if (evt_if.evt_valid === 1'b1) begin
                if (evt_if.evt_id === 2'd0) ch0_grants++;
                if (evt_if.evt_id === 2'd3) ch3_grants++;
                if (waiting != 0) begin
                    offers++;
                    if (evt_if.evt_id === 2'd3) begin
                        waiting = 0;
                    end else if (offers >= 2) begin
                        waiting = 0;
                        checks++;
                        errors++;
                        $display("FAIL fair_ch3: not granted in %0d handshakes want <=2",
                                 offers);
                    end
                end
            end
        end
        edge_pulse = '0;
        checks++;
        if (ch3_grants !== 2) begin
            errors++;
            $display("FAIL fair_ch3_count: got %0d want 2", ch3_grants);
        end
        checks++;
        if (ch0_grants < 90) begin
            errors++;
            $display("FAIL fair_ch0_count: got %0d want >=90", ch0_grants);
        end
        step();
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        evt_if.evt_ready = 1'b0;
        edge_pulse = 4'b0100;
        step();
        edge_pulse = '0;
        step();
        edge_pulse = 4'b1100;
        step();
        edge_pulse = '0;
        checks++;
        if (evt_if.evt_valid !== 1'b1 || pending !== 4'b1100) begin
            errors++;
            $display("FAIL areset_setup: valid=%b pending=%b want 1/1100",
                     evt_if.evt_valid, pending);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (evt_if.evt_valid !== 1'b0 || pending !== 4'b0000
            || evt_if.evt_id !== 2'd0) begin
            errors++;
            $display("FAIL areset_now: valid=%b pending=%b id=%0d want 0/0000/0",
                     evt_if.evt_valid, pending, evt_if.evt_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
        evt_if.evt_ready = 1'b1;
        edge_pulse = 4'b1111;
        step();
        edge_pulse = '0;
        step();
        checks++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 2'd0) begin
            errors++;
            $display("FAIL areset_first: valid=%b id=%0d want 1/0",
                     evt_if.evt_valid, evt_if.evt_id);
        end
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_random();
        logic [N-1:0] p;
        logic         r;
        int           bad;
        do_reset();
        model_reset();
        bad = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            p = (cyc < 700) ? N'($urandom) : N'($urandom & $urandom);
            r = ($urandom_range(0, 3) != 0);
            edge_pulse       = p;
            evt_if.evt_ready = r;
            step();
            model_edge(p, r);
            checks++;
            if (evt_if.evt_valid !== m_valid || pending !== m_pend
                || (m_valid && evt_if.evt_id !== 2'(m_id))) begin
                errors++;
                if (bad < 10)
                    $display("FAIL rand_c%0d: valid=%b id=%0d pending=%b want %b/%0d/%b",
                             cyc, evt_if.evt_valid, evt_if.evt_id, pending,
                             m_valid, m_id, m_pend);
                bad++;
            end
`ifdef EDGE_ARB_DROP_CNT_EN
            checks++;
            if (drop_cnt !== DW'(m_drop)) begin
                errors++;
                if (bad < 10)
                    $display("FAIL rand_drop_c%0d: got %0d want %0d",
                             cyc, drop_cnt, m_drop);
                bad++;
            end
`endif
        end
        edge_pulse       = '0;
        evt_if.evt_ready = 1'b1;
    endtask

    initial begin
        evt_if.evt_ready = 1'b1;
        test_reset();
        test_single();
        test_burst();
        test_stall();
        test_fairness();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
